// File: rtl/cla_pipelined_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake and status flags.
// Optional signed saturation is built only when CLA_PIPE_SAT_EN is defined.
module cla_pipelined_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             c_in,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned NG   = SEG / 4;
    localparam int unsigned MW   = (NG > 4) ? NG : 4;
    localparam int unsigned PD   = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int unsigned LAST = STAGES - 1;

    typedef struct packed {
        logic [SEG-1:0] s;
        logic           co;
        logic           cm;
    } seg_res_t;

    // Flat sum-of-products carry into position n from c0 and per-position p/g.
    function automatic logic la_carry(input logic [MW-1:0] p, input logic [MW-1:0] g,
                                      input logic c0, input int unsigned n);
        logic c, term;
        c = c0;
        for (int unsigned j = 0; j < MW; j++) if (j < n) c = c & p[j];
        for (int unsigned i = 0; i < MW; i++) begin
            if (i < n) begin
                term = g[i];
                for (int unsigned j = 0; j < MW; j++) if (j > i && j < n) term = term & p[j];
                c = c | term;
            end
        end
        return c;
    endfunction

    function automatic seg_res_t seg_add(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                         input logic c0);
        logic [SEG-1:0] p, g, cb;
        logic [MW-1:0]  gp, gg, bp, bg;
        logic [NG:0]    gc;
        seg_res_t       res;
        p  = a ^ b;
        g  = a & b;
        gp = '0;
        gg = '0;
        for (int unsigned j = 0; j < NG; j++) begin
            bp      = '0;
            bg      = '0;
            bp[3:0] = p[4*j +: 4];
            bg[3:0] = g[4*j +: 4];
            gp[j]   = &bp[3:0];
            gg[j]   = la_carry(bp, bg, 1'b0, 4);
        end
        for (int unsigned j = 0; j <= NG; j++) gc[j] = la_carry(gp, gg, c0, j);
        for (int unsigned j = 0; j < NG; j++) begin
            bp      = '0;
            bg      = '0;
            bp[3:0] = p[4*j +: 4];
            bg[3:0] = g[4*j +: 4];
            for (int unsigned i = 0; i < 4; i++) cb[4*j+i] = la_carry(bp, bg, gc[j], i);
        end
        res.s  = p ^ cb;
        res.co = gc[NG];
        res.cm = cb[SEG-1];
        return res;
    endfunction

    logic [WIDTH-1:0] a_q [PD];
    logic [WIDTH-1:0] b_q [PD];
    logic [WIDTH-1:0] r_q [PD];
    logic             c_q [PD];
    logic             v_q [PD];

    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_r [STAGES];
    logic             st_c [STAGES];
    logic             st_v [STAGES];
    logic [WIDTH-1:0] nx_r [STAGES];
    seg_res_t         st_sr [STAGES];

    logic [WIDTH-1:0] ans_n;
    logic             co_n, ovf_n, stall;

`ifdef CLA_PIPE_SAT_EN
    logic sat_q [PD];
    logic st_sat [STAGES];
`else
    logic unused_sat;
    assign unused_sat = sat;
`endif

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Stage inputs: stage 0 from the ports, later stages from the previous stage register.
    always_comb begin
        st_a[0] = num1;
        st_b[0] = sub ? ~num2 : num2;
        st_c[0] = sub ? 1'b1 : c_in;
        st_r[0] = '0;
        st_v[0] = in_valid;
`ifdef CLA_PIPE_SAT_EN
        st_sat[0] = sat;
`endif
        for (int unsigned k = 1; k < STAGES; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_c[k] = c_q[k-1];
            st_r[k] = r_q[k-1];
            st_v[k] = v_q[k-1];
`ifdef CLA_PIPE_SAT_EN
            st_sat[k] = sat_q[k-1];
`endif
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            st_sr[k] = seg_add(st_a[k][k*SEG +: SEG], st_b[k][k*SEG +: SEG], st_c[k]);
            nx_r[k]  = st_r[k];
            nx_r[k][k*SEG +: SEG] = st_sr[k].s;
        end
    end

    always_comb begin
        co_n  = st_sr[LAST].co;
        ovf_n = st_sr[LAST].cm ^ co_n;
        ans_n = nx_r[LAST];
`ifdef CLA_PIPE_SAT_EN
        // Overflow implies equal effective signs, so A's sign picks the clamp rail.
        if (st_sat[LAST] && ovf_n) begin
            ans_n = st_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < PD; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
`ifdef CLA_PIPE_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
            out_valid <= 1'b0;
            ans       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else if (!stall) begin
            for (int unsigned k = 0; k < STAGES - 1; k++) begin
                a_q[k] <= st_a[k];
                b_q[k] <= st_b[k];
                r_q[k] <= nx_r[k];
                c_q[k] <= st_sr[k].co;
                v_q[k] <= st_v[k];
`ifdef CLA_PIPE_SAT_EN
                sat_q[k] <= st_sat[k];
`endif
            end
            out_valid <= st_v[LAST];
            ans       <= ans_n;
            c_out     <= co_n;
            ovf       <= ovf_n;
            zero      <= (ans_n == '0);
            neg       <= ans_n[WIDTH-1];
        end
    end
endmodule

// File: tb/tb_cla_pipelined_addsub.sv
// Directed-vector bench for cla_pipelined_addsub at STAGES=2, plus STAGES=1/4 latency checks.
module tb_cla_pipelined_addsub;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, c_in, sub, sat;
    logic [31:0] num1, num2;

    logic        d1_in_ready, d1_out_valid, d1_c_out, d1_ovf, d1_zero, d1_neg;
    logic        d2_in_ready, d2_out_valid, d2_c_out, d2_ovf, d2_zero, d2_neg;
    logic        d4_in_ready, d4_out_valid, d4_c_out, d4_ovf, d4_zero, d4_neg;
    logic [31:0] d1_ans, d2_ans, d4_ans;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cla_pipelined_addsub #(.WIDTH(32), .STAGES(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready), .num1(num1),
        .num2(num2), .c_in(c_in), .sub(sub), .sat(sat), .out_valid(d2_out_valid),
        .out_ready(out_ready), .ans(d2_ans), .c_out(d2_c_out), .ovf(d2_ovf), .zero(d2_zero),
        .neg(d2_neg)
    );

    cla_pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d1_in_ready), .num1(num1),
        .num2(num2), .c_in(c_in), .sub(sub), .sat(sat), .out_valid(d1_out_valid),
        .out_ready(out_ready), .ans(d1_ans), .c_out(d1_c_out), .ovf(d1_ovf), .zero(d1_zero),
        .neg(d1_neg)
    );

    cla_pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d4_in_ready), .num1(num1),
        .num2(num2), .c_in(c_in), .sub(sub), .sat(sat), .out_valid(d4_out_valid),
        .out_ready(out_ready), .ans(d4_ans), .c_out(d4_c_out), .ovf(d4_ovf), .zero(d4_zero),
        .neg(d4_neg)
    );

    typedef struct {
        logic [31:0] a, b;
        logic        ci, sb, st;
        logic [31:0] ans;
        logic        co, ov, z, n;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic sb, input logic st);
        num1 = a; num2 = b; c_in = ci; sub = sb; sat = st;
    endtask

    initial begin
        int sent, rcv, seen;
        logic acc, cons;

        vecs[0]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{32'h00000007, 32'h00000007, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef CLA_PIPE_SAT_EN
        vecs[4]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        vecs[4]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        vecs[5]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 1'b0, 32'hACF13569, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 1'b0, 32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("reset out_valid", d2_out_valid, 0);
        chk("reset ans", d2_ans, 0);
        chk("reset flags", {d2_c_out, d2_ovf, d2_zero, d2_neg}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("in_ready after reset", d2_in_ready, 1);

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb, vecs[i].st);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d early out_valid", i), d2_out_valid, 0);
            tick();
            chk($sformatf("v%0d out_valid", i), d2_out_valid, 1);
            chk($sformatf("v%0d ans", i), d2_ans, vecs[i].ans);
            chk($sformatf("v%0d c_out", i), d2_c_out, vecs[i].co);
            chk($sformatf("v%0d ovf", i), d2_ovf, vecs[i].ov);
            chk($sformatf("v%0d zero", i), d2_zero, vecs[i].z);
            chk($sformatf("v%0d neg", i), d2_neg, vecs[i].n);
        end

        // Latency across 1/2/4 stages for the same full carry chain.
        repeat (5) tick();
        drive(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("s1 out_valid", d1_out_valid, 1);
        chk("s1 ans", d1_ans, 0);
        chk("s1 c_out", d1_c_out, 1);
        chk("s2 early", d2_out_valid, 0);
        chk("s4 early1", d4_out_valid, 0);
        tick();
        chk("s2 out_valid", d2_out_valid, 1);
        chk("s2 ans", d2_ans, 0);
        chk("s2 c_out", d2_c_out, 1);
        chk("s4 early2", d4_out_valid, 0);
        tick();
        chk("s4 early3", d4_out_valid, 0);
        tick();
        chk("s4 out_valid", d4_out_valid, 1);
        chk("s4 ans", d4_ans, 0);
        chk("s4 c_out", d4_c_out, 1);
        chk("s4 zero", d4_zero, 1);
        repeat (3) tick();

        // Streaming with backpressure in cycles 3..5.
        sent = 0; rcv = 0;
        for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 8);
            drive(sent, sent * 32'h100, 1'b0, 1'b0, 1'b0);
            #1;
            if (cyc >= 3 && cyc <= 5) chk($sformatf("stall in_ready c%0d", cyc), d2_in_ready, 0);
            acc  = in_valid && d2_in_ready;
            cons = d2_out_valid && out_ready;
            if (cons) begin
                chk($sformatf("stream ans %0d", rcv), d2_ans, rcv * 32'h101);
                chk($sformatf("stream c_out %0d", rcv), d2_c_out, 0);
                rcv++;
            end
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream count", rcv, 8);
        seen = 0;
        repeat (4) begin
            tick();
            if (d2_out_valid) seen++;
        end
        chk("stream no extra", seen, 0);

        // Reset with two operations in flight.
        drive(32'h3, 32'h4, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        drive(32'h5, 32'h6, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("pre-reset out_valid", d2_out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid reset out_valid", d2_out_valid, 0);
        chk("mid reset ans", d2_ans, 0);
        chk("mid reset flags", {d2_c_out, d2_ovf, d2_zero, d2_neg}, 0);
        chk("mid reset s4 out_valid", d4_out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            tick();
            if (d2_out_valid || d4_out_valid || d1_out_valid) seen++;
        end
        chk("no stale after reset", seen, 0);
        chk("in_ready after mid reset", d2_in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
